// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: PCSrc encodings, exception vectors,
// the IF/ID register layout and the supervisor-preserving PC increment.
package mips_pkg;

  localparam logic [2:0] PC_SEQ   = 3'b000;
  localparam logic [2:0] PC_BR    = 3'b001;
  localparam logic [2:0] PC_J     = 3'b010;
  localparam logic [2:0] PC_JR    = 3'b011;
  localparam logic [2:0] PC_ILLOP = 3'b100;
  localparam logic [2:0] PC_XADR  = 3'b101;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Bit 31 is the supervisor flag; only the low 31 bits count and wrap.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a level signal from another clock domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// the synchronised, supervisor-masked interrupt request.
module if_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] reg_target,
  input  logic        irq_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        irq
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic [2:0]  eff_src;
  logic        redirect;
  logic        irq_s;
  if_id_t      if_id;

  assign pc_plus4  = pc_inc(pc);
  assign imem_addr = pc;

  // A bubble in IF/ID carries no decoded control, so its PCSrc is ignored.
  assign eff_src = if_id.valid ? pc_src : PC_SEQ;

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = pc_plus4;
    case (eff_src)
      PC_BR: begin
        if (branch_taken) begin
          redirect    = 1'b1;
          redirect_pc = branch_target;
        end
      end
      PC_J: begin
        redirect    = 1'b1;
        redirect_pc = jump_target;
      end
      PC_JR: begin
        redirect    = 1'b1;
        redirect_pc = reg_target;
      end
      PC_ILLOP: begin
        redirect    = 1'b1;
        redirect_pc = ILLOP_PC;
      end
      PC_XADR: begin
        redirect    = 1'b1;
        redirect_pc = XADR_PC;
      end
      default: ;
    endcase
  end

  // Flow control: a redirect overrides stall and squashes the wrong-path
  // fetch; otherwise stall holds PC and IF/ID; otherwise one fetch per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id.instr    <= NOP;
      if_id.pc_plus4 <= 32'h0;
      if_id.valid    <= 1'b0;
    end else if (redirect) begin
      if_id.instr <= NOP;
      if_id.valid <= 1'b0;
    end else if (!stall) begin
      if_id.instr    <= imem_rdata;
      if_id.pc_plus4 <= pc_plus4;
      if_id.valid    <= 1'b1;
    end
  end

  assign if_id_instr    = if_id.instr;
  assign if_id_pc_plus4 = if_id.pc_plus4;
  assign if_id_valid    = if_id.valid;

  sync2 u_irq_sync (
    .clk (clk),
    .rst (reset),
    .d   (irq_req),
    .q   (irq_s)
  );

  // Interrupts are only taken against a real user-mode instruction.
  assign irq = irq_s & if_id.valid & ~if_id.pc_plus4[31];

endmodule
